// File: rtl/control_logic_if.sv
// Decoder bus: the instruction and its address go in, and the datapath control selects and enables come out.
// The master drives inst/pc and the slave (control_logic) drives the controls.
interface control_logic_if;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        reg_wen;
    logic [2:0]  imm_sel;
    logic        br_un;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [3:0]  alu_sel;
    logic        mem_wen;
    logic [1:0]  wb_sel;
    logic        csr_sel;
    logic        csr_wen;

    modport master (
        output inst, pc,
        input  reg_wen, imm_sel, br_un, a_sel, b_sel, alu_sel,
               mem_wen, wb_sel, csr_sel, csr_wen
    );

    modport slave (
        input  inst, pc,
        output reg_wen, imm_sel, br_un, a_sel, b_sel, alu_sel,
               mem_wen, wb_sel, csr_sel, csr_wen
    );
endinterface

// File: rtl/control_logic.sv
// RV32I single-cycle control decoder with write enables gated by an armed-after-reset flag.
// Optional CSR decoding (csrrw/csrrwi) is enabled by defining CONTROL_CSR_EN.
module control_logic (
    input  logic            clk,
    input  logic            rst_n,
    control_logic_if.slave  bus
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_U    = 3'b011,
        IMM_J    = 3'b100,
        IMM_ZIMM = 3'b101
    } imm_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_e;

    logic [2:0] funct3;
    logic       armed;
    logic       reg_wen_raw;
    logic       mem_wen_raw;
    logic       csr_wen_raw;
    logic       csr_sel_raw;
    logic [2:0] imm_sel_c;
    logic       br_un_c;
    logic [1:0] a_sel_c;
    logic [1:0] b_sel_c;
    logic [3:0] alu_sel_c;
    logic [1:0] wb_sel_c;

    assign funct3 = bus.inst[14:12];

    // pc and the register/immediate fields do not influence any control output.
    logic unused_bits;
    assign unused_bits = ^{bus.pc, bus.inst[31], bus.inst[29:15], bus.inst[11:7]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no case path can infer a latch.
        reg_wen_raw = 1'b0;
        mem_wen_raw = 1'b0;
        csr_wen_raw = 1'b0;
        csr_sel_raw = 1'b0;
        imm_sel_c   = IMM_I;
        br_un_c     = 1'b0;
        a_sel_c     = 2'd0;
        b_sel_c     = 2'd0;
        alu_sel_c   = 4'b0000;
        wb_sel_c    = WB_ALU;

        case (bus.inst[6:0])
            OP_R: begin
                reg_wen_raw = 1'b1;
                alu_sel_c   = {bus.inst[30], funct3};
            end
            OP_I: begin
                reg_wen_raw = 1'b1;
                b_sel_c     = 2'd1;
                // Only the shift-right encoding carries the arithmetic/logical bit in inst[30].
                alu_sel_c   = (funct3 == 3'b101) ? {bus.inst[30], funct3} : {1'b0, funct3};
            end
            OP_LOAD: begin
                reg_wen_raw = 1'b1;
                b_sel_c     = 2'd1;
                wb_sel_c    = WB_MEM;
            end
            OP_STORE: begin
                mem_wen_raw = 1'b1;
                imm_sel_c   = IMM_S;
                b_sel_c     = 2'd1;
            end
            OP_BRANCH: begin
                imm_sel_c = IMM_B;
                a_sel_c   = 2'd1;
                b_sel_c   = 2'd1;
                br_un_c   = funct3[1];
            end
            OP_JAL: begin
                reg_wen_raw = 1'b1;
                imm_sel_c   = IMM_J;
                a_sel_c     = 2'd1;
                b_sel_c     = 2'd1;
                wb_sel_c    = WB_PC4;
            end
            OP_JALR: begin
                reg_wen_raw = 1'b1;
                b_sel_c     = 2'd1;
                wb_sel_c    = WB_PC4;
            end
            OP_LUI: begin
                reg_wen_raw = 1'b1;
                imm_sel_c   = IMM_U;
                b_sel_c     = 2'd1;
                wb_sel_c    = WB_MEM;
            end
            OP_AUIPC: begin
                reg_wen_raw = 1'b1;
                imm_sel_c   = IMM_U;
                a_sel_c     = 2'd1;
                b_sel_c     = 2'd1;
            end
`ifdef CONTROL_CSR_EN
            OP_SYSTEM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    csr_wen_raw = 1'b1;
                    reg_wen_raw = 1'b1;
                    imm_sel_c   = IMM_ZIMM;
                    b_sel_c     = 2'd1;
                    wb_sel_c    = WB_CSR;
                    csr_sel_raw = funct3[2];
                end
            end
`endif
            default: ;
        endcase
    end

    assign bus.imm_sel = imm_sel_c;
    assign bus.br_un   = br_un_c;
    assign bus.a_sel   = a_sel_c;
    assign bus.b_sel   = b_sel_c;
    assign bus.alu_sel = alu_sel_c;
    assign bus.wb_sel  = wb_sel_c;

    // rst_n gates directly so enables drop in the same delta as reset, not after the flag clears.
    assign bus.reg_wen = reg_wen_raw & armed & rst_n;
    assign bus.mem_wen = mem_wen_raw & armed & rst_n;

`ifdef CONTROL_CSR_EN
    assign bus.csr_wen = csr_wen_raw & armed & rst_n;
    assign bus.csr_sel = csr_sel_raw;
`else
    logic unused_csr;
    assign unused_csr  = csr_wen_raw ^ csr_sel_raw;
    assign bus.csr_wen = 1'b0;
    assign bus.csr_sel = 1'b0;
`endif

endmodule

// File: tb/tb_control_logic.sv
// Directed testbench for control_logic: the reset/arming sequence and the decode of each opcode class.
// The CSR vectors expect the decoded result when CONTROL_CSR_EN is defined and all-zero outputs otherwise.
module tb_control_logic;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    control_logic_if bus ();

    control_logic dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Packed order: reg_wen, imm_sel, br_un, a_sel, b_sel, alu_sel, mem_wen, wb_sel, csr_sel, csr_wen.
    function automatic logic [17:0] pack(
        input logic       reg_wen, input logic [2:0] imm_sel, input logic br_un,
        input logic [1:0] a_sel,   input logic [1:0] b_sel,   input logic [3:0] alu_sel,
        input logic       mem_wen, input logic [1:0] wb_sel,
        input logic       csr_sel, input logic csr_wen);
        return {reg_wen, imm_sel, br_un, a_sel, b_sel, alu_sel, mem_wen, wb_sel, csr_sel, csr_wen};
    endfunction

    function automatic logic [17:0] observed();
        return {bus.reg_wen, bus.imm_sel, bus.br_un, bus.a_sel, bus.b_sel, bus.alu_sel,
                bus.mem_wen, bus.wb_sel, bus.csr_sel, bus.csr_wen};
    endfunction

    // Drive on the falling edge and sample 1 ns later, well away from the rising edge.
    task automatic apply(input logic [31:0] inst);
        @(negedge clk);
        bus.inst = inst;
        #1;
    endtask

    task automatic decode(input string tag, input logic [31:0] inst, input logic [17:0] exp);
        apply(inst);
        check(tag, {14'd0, observed()}, {14'd0, exp});
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        bus.pc  = 32'h0000_1000;
        bus.inst = 32'h0011_2223;

        // Reset: enables held low while the selects still follow inst.
        #2;
        check("rst_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
        check("rst_imm_sel", {29'd0, bus.imm_sel}, 32'd1);
        @(posedge clk);
        #1;
        check("rst_hold_mem_wen", {31'd0, bus.mem_wen}, 32'd0);

        // Release away from an edge; arming waits for the next rising clk.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pre_arm_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
        @(posedge clk);
        #1;
        check("armed_mem_wen", {31'd0, bus.mem_wen}, 32'd1);

        // Mid-operation reset must kill the enable before any clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reassert_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
        check("reassert_imm_sel", {29'd0, bus.imm_sel}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rearm_mem_wen", {31'd0, bus.mem_wen}, 32'd1);

        //                                    reg imm     br a     b     alu      mem wb    cs cw
        decode("addi",   32'h0020_0013, pack(1, 3'b000, 0, 2'd0, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        decode("slti",   32'h0021_2093, pack(1, 3'b000, 0, 2'd0, 2'd1, 4'b0010, 0, 2'd0, 0, 0));
        decode("srai",   32'h4030_D093, pack(1, 3'b000, 0, 2'd0, 2'd1, 4'b1101, 0, 2'd0, 0, 0));
        decode("addi_b30", 32'h4001_0093, pack(1, 3'b000, 0, 2'd0, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        decode("sub",    32'h4031_00B3, pack(1, 3'b000, 0, 2'd0, 2'd0, 4'b1000, 0, 2'd0, 0, 0));
        decode("jal",    32'h0080_00EF, pack(1, 3'b100, 0, 2'd1, 2'd1, 4'b0000, 0, 2'd2, 0, 0));
        decode("jalr",   32'h0081_00E7, pack(1, 3'b000, 0, 2'd0, 2'd1, 4'b0000, 0, 2'd2, 0, 0));
        decode("bltu",   32'h0231_6063, pack(0, 3'b010, 1, 2'd1, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        decode("beq",    32'h0031_0863, pack(0, 3'b010, 0, 2'd1, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        decode("sw",     32'h0011_2223, pack(0, 3'b001, 0, 2'd0, 2'd1, 4'b0000, 1, 2'd0, 0, 0));
        decode("lw",     32'h0031_A203, pack(1, 3'b000, 0, 2'd0, 2'd1, 4'b0000, 0, 2'd1, 0, 0));
        decode("lui",    32'h0000_1137, pack(1, 3'b011, 0, 2'd0, 2'd1, 4'b0000, 0, 2'd1, 0, 0));
        decode("auipc",  32'h0001_0097, pack(1, 3'b011, 0, 2'd1, 2'd1, 4'b0000, 0, 2'd0, 0, 0));
        decode("unknown", 32'h0000_007F, pack(0, 3'b000, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 0, 0));
        decode("ecall",  32'h0000_0073, pack(0, 3'b000, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 0, 0));
`ifdef CONTROL_CSR_EN
        decode("csrrw",  32'h51E0_9073, pack(1, 3'b101, 0, 2'd0, 2'd1, 4'b0000, 0, 2'd3, 0, 1));
        decode("csrrwi", 32'h51E2_D073, pack(1, 3'b101, 0, 2'd0, 2'd1, 4'b0000, 0, 2'd3, 1, 1));
        decode("csrrs",  32'h51E0_A073, pack(0, 3'b000, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 0, 0));
`else
        decode("csrrw",  32'h51E0_9073, pack(0, 3'b000, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 0, 0));
        decode("csrrwi", 32'h51E2_D073, pack(0, 3'b000, 0, 2'd0, 2'd0, 4'b0000, 0, 2'd0, 0, 0));
`endif

        // Reset with a register-writing instruction: enables low, selects unchanged.
        apply(32'h0080_00EF);
        rst_n = 1'b0;
        #1;
        check("rst_jal", {14'd0, observed()},
              {14'd0, pack(0, 3'b100, 0, 2'd1, 2'd1, 4'b0000, 0, 2'd2, 0, 0)});
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_logic.md
CONTROL_LOGIC -- requirements
Module: control_logic

Interface
REQ-001 clk  input  1  rising-edge clock; used only by the write-enable arming flag.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 inst  input  32  RV32I instruction being decoded.
REQ-004 pc  input  32  address of inst; reserved, has no effect on any output.
REQ-005 reg_wen  output  1  register-file write enable.
REQ-006 imm_sel  output  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 CSR zimm.
REQ-007 br_un  output  1  unsigned branch compare.
REQ-008 a_sel  output  2  ALU A operand: 0 rs1, 1 PC, 2-3 unused.
REQ-009 b_sel  output  2  ALU B operand: 0 rs2, 1 immediate, 2-3 unused.
REQ-010 alu_sel  output  4  ALU operation.
REQ-011 mem_wen  output  1  data-memory write enable.
REQ-012 wb_sel  output  2  writeback source: 0 ALU, 1 load/upper-immediate path, 2 PC+4, 3 CSR read data.
REQ-013 csr_sel  output  1  CSR write source: 0 rs1, 1 zimm.
REQ-014 csr_wen  output  1  CSR write enable.

Function
REQ-015 All outputs SHALL be combinational functions of inst, with zero-cycle latency, except for the enable gating in REQ-025.
REQ-016 R-type (0110011) SHALL decode as: reg_wen 1; a_sel 0; b_sel 0; wb_sel 0; alu_sel {inst[30],funct3}.
REQ-017 I-arith (0010011) SHALL decode as: reg_wen 1; imm_sel 000; a_sel 0; b_sel 1; wb_sel 0; alu_sel {0,funct3}, except funct3=101, where alu_sel is {inst[30],101}.
REQ-018 Load (0000011) SHALL decode as: reg_wen 1; imm_sel 000; a_sel 0; b_sel 1; alu_sel 0000; wb_sel 1.
REQ-019 Store (0100011) SHALL decode as: mem_wen 1; reg_wen 0; imm_sel 001; a_sel 0; b_sel 1; alu_sel 0000.
REQ-020 Branch (1100011) SHALL decode as: reg_wen 0; imm_sel 010; a_sel 1; b_sel 1; alu_sel 0000; br_un = funct3[1].
REQ-021 JAL (1101111) SHALL decode as: reg_wen 1; imm_sel 100; a_sel 1; b_sel 1; alu_sel 0000; wb_sel 2.
REQ-022 JALR (1100111) SHALL decode as: reg_wen 1; imm_sel 000; a_sel 0; b_sel 1; alu_sel 0000; wb_sel 2.
REQ-023 LUI (0110111) SHALL decode as: reg_wen 1; imm_sel 011; a_sel 0; b_sel 1; wb_sel 1.
- AUIPC (0010111) SHALL decode as: reg_wen 1; imm_sel 011; a_sel 1; b_sel 1; alu_sel 0000; wb_sel 0.
REQ-024 Any output not listed for an opcode SHALL be 0.
- An unknown opcode SHALL drive every output to 0.
- br_un SHALL be 0 for all non-branch instructions.
REQ-025 reg_wen, mem_wen and csr_wen SHALL be forced to 0 whenever rst_n is low or the internal armed flag is 0.

Reset
REQ-026 rst_n low SHALL asynchronously clear the armed flag.
REQ-027 The armed flag SHALL set on the first rising clk edge with rst_n high.
REQ-028 Select outputs SHALL keep following inst during and after reset.
REQ-029 Asserting reset mid-operation SHALL drop all three enables within the same delta cycle.

Configuration
REQ-030 With CONTROL_CSR_EN defined, SYSTEM (1110011) with funct3 001 (csrrw) or 101 (csrrwi) SHALL decode as: csr_wen 1; reg_wen 1; imm_sel 101; a_sel 0; b_sel 1; wb_sel 3; csr_sel = funct3[2].
- Other SYSTEM funct3 values SHALL decode as unknown.
REQ-031 Without CONTROL_CSR_EN, SYSTEM SHALL decode as unknown, and csr_wen/csr_sel SHALL be constant 0.

Verification
REQ-032 Armed, inst 00200013 -> imm_sel 000, alu_sel 0000, a_sel 0, b_sel 1, wb_sel 0, reg_wen 1.
REQ-033 inst 008000EF -> imm_sel 100, a_sel 1, b_sel 1, wb_sel 2, reg_wen 1.
- inst 008100E7 -> imm_sel 000, a_sel 0, wb_sel 2.
REQ-034 inst 02316063 -> imm_sel 010, a_sel 1, b_sel 1, reg_wen 0, br_un 1.
- inst 00310863 -> br_un 0.
REQ-035 inst 00112223 -> imm_sel 001, mem_wen 1, reg_wen 0.
- inst 0031A203 -> wb_sel 1, reg_wen 1.
REQ-036 With CONTROL_CSR_EN: inst 51E09073 -> imm_sel 101, a_sel 0, csr_sel 0, csr_wen 1.
- inst 00001137 -> imm_sel 011, a_sel 0, wb_sel 1.
- inst 00010097 -> a_sel 1, wb_sel 0.
REQ-037 Hold rst_n low with inst 00112223 -> mem_wen 0.
- Release rst_n, then one clk edge -> mem_wen 1.
- Re-assert rst_n -> mem_wen 0 immediately.
